// File: rtl/hazard_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    localparam int REG_AW_DEF    = 5;
    localparam int LDU_CYC_DEF   = 1;
    localparam int FLUSH_CYC_DEF = 1;
    localparam int CNT_W_DEF     = 16;
    localparam int REM_W         = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: register indices in, forwarding/stall controls out.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
);
    logic [REG_AW-1:0] rs1_id;
    logic [REG_AW-1:0] rs2_id;
    logic [REG_AW-1:0] rs1_ex;
    logic [REG_AW-1:0] rs2_ex;
    logic [REG_AW-1:0] rd_ex;
    logic              load_ex;
    logic [REG_AW-1:0] rd_mem;
    logic              wr_mem;
    logic [REG_AW-1:0] rd_wb;
    logic              wr_wb;
    logic              branch_taken_ex;
    logic [1:0]        src1_fwd;
    logic [1:0]        src2_fwd;
    logic              stall_if_id;
    logic              bubble_ex;
    logic              flush_if_id;

    // Pipeline side
    modport master (
        output rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, load_ex,
               rd_mem, wr_mem, rd_wb, wr_wb, branch_taken_ex,
        input  src1_fwd, src2_fwd, stall_if_id, bubble_ex, flush_if_id
    );

    // Hazard controller side
    modport slave (
        input  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, load_ex,
               rd_mem, wr_mem, rd_wb, wr_wb, branch_taken_ex,
        output src1_fwd, src2_fwd, stall_if_id, bubble_ex, flush_if_id
    );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forwarding source select for one EX operand; the youngest producer (MEM) wins over WB.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              wr_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              wr_wb,
    output fwd_sel_t          sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so a write to it never produces a forwardable value
    assign mem_hit = wr_mem && (rd_mem == src) && (rd_mem != '0);
    assign wb_hit  = wr_wb  && (rd_wb  == src) && (rd_wb  != '0);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stall and branch flush sequencing.
// Optional saturating stall/flush performance counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int LDU_CYC   = LDU_CYC_DEF,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [REM_W-1:0] LDU_REM   = REM_W'(LDU_CYC - 1);
    localparam logic [REM_W-1:0] FLUSH_REM = REM_W'(FLUSH_CYC - 1);

    hz_state_t        state_reg, state_next;
    logic [REM_W-1:0] rem_reg, rem_next;
    logic             ldu_hit;
    logic             stall_now;
    logic             bubble_now;
    logic             flush_now;

    logic [REG_AW-1:0] src_ex  [2];
    fwd_sel_t          fwd_sel [2];

    assign src_ex[0] = hz.rs1_ex;
    assign src_ex[1] = hz.rs2_ex;

    // Forwarding is purely combinational and ignores FSM state and reset
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        hazard_fwd_sel #(
            .REG_AW (REG_AW)
        ) u_fwd_sel (
            .src    (src_ex[gi]),
            .rd_mem (hz.rd_mem),
            .wr_mem (hz.wr_mem),
            .rd_wb  (hz.rd_wb),
            .wr_wb  (hz.wr_wb),
            .sel    (fwd_sel[gi])
        );
    end

    assign hz.src1_fwd = fwd_sel[0];
    assign hz.src2_fwd = fwd_sel[1];

    assign ldu_hit = hz.load_ex && (hz.rd_ex != '0) &&
                     ((hz.rd_ex == hz.rs1_id) || (hz.rd_ex == hz.rs2_id));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        case (state_reg)
            ST_RUN, ST_LDSTALL: begin
                // A taken branch kills whatever the stall was protecting
                if (hz.branch_taken_ex) begin
                    if (FLUSH_CYC > 1) begin
                        state_next = ST_FLUSH;
                        rem_next   = FLUSH_REM;
                    end else begin
                        state_next = ST_RUN;
                        rem_next   = '0;
                    end
                end else if (state_reg == ST_LDSTALL) begin
                    rem_next = rem_reg - 1'b1;
                    if (rem_reg <= REM_W'(1)) begin
                        state_next = ST_RUN;
                        rem_next   = '0;
                    end
                end else if (ldu_hit && (LDU_CYC > 1)) begin
                    state_next = ST_LDSTALL;
                    rem_next   = LDU_REM;
                end
            end
            ST_FLUSH: begin
                rem_next = rem_reg - 1'b1;
                if (rem_reg <= REM_W'(1)) begin
                    state_next = ST_RUN;
                    rem_next   = '0;
                end
            end
            default: begin
                state_next = ST_RUN;
                rem_next   = '0;
            end
        endcase
    end

    always_comb begin
        stall_now  = 1'b0;
        bubble_now = 1'b0;
        flush_now  = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_RUN: begin
                    if (hz.branch_taken_ex) begin
                        flush_now  = 1'b1;
                        bubble_now = 1'b1;
                    end else if (ldu_hit) begin
                        stall_now  = 1'b1;
                        bubble_now = 1'b1;
                    end
                end
                ST_LDSTALL: begin
                    if (hz.branch_taken_ex) begin
                        flush_now  = 1'b1;
                    end else begin
                        stall_now  = 1'b1;
                    end
                    bubble_now = 1'b1;
                end
                ST_FLUSH: begin
                    flush_now  = 1'b1;
                    bubble_now = 1'b1;
                end
                default: begin
                    stall_now  = 1'b0;
                end
            endcase
        end
    end

    assign hz.stall_if_id = stall_now;
    assign hz.bubble_ex   = bubble_now;
    assign hz.flush_if_id = flush_now;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_now && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (flush_now && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed corner sequences followed by random traffic.
// Counter checks are active when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int REG_AW    = 5;
    localparam int LDU_CYC   = 2;
    localparam int FLUSH_CYC = 3;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct {
        bit       rst_n;
        bit [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
        bit       load_ex, wr_mem, wr_wb, br;
    } stim_t;

    typedef struct {
        int    f1, f2, st, bu, fl, scnt, fcnt;
        bit    chk_run;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    hazard_ctrl #(
        .REG_AW    (REG_AW),
        .LDU_CYC   (LDU_CYC),
        .FLUSH_CYC (FLUSH_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hz        (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    exp_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   txn_no        = 0;

    // Reference model: outstanding penalty kind (0 none, 1 stall, 2 flush) and cycles left
    int pen_kind = 0;
    int pen_left = 0;
    int n_stall  = 0;
    int n_flush  = 0;

    function automatic int fwd_model(bit [4:0] src, bit [4:0] rdm, bit wm, bit [4:0] rdw, bit ww);
        if (wm && rdm == src && rdm != 0) return 2;
        if (ww && rdw == src && rdw != 0) return 1;
        return 0;
    endfunction

    function automatic int sat(int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst_n              = s.rst_n;
        hz.rs1_id          = s.rs1_id;
        hz.rs2_id          = s.rs2_id;
        hz.rs1_ex          = s.rs1_ex;
        hz.rs2_ex          = s.rs2_ex;
        hz.rd_ex           = s.rd_ex;
        hz.load_ex         = s.load_ex;
        hz.rd_mem          = s.rd_mem;
        hz.wr_mem          = s.wr_mem;
        hz.rd_wb           = s.rd_wb;
        hz.wr_wb           = s.wr_wb;
        hz.branch_taken_ex = s.br;
    endtask

    task automatic step(input stim_t s, input string tag, input bit chk_run);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        apply(s);
        lu = s.load_ex && s.rd_ex != 0 && (s.rd_ex == s.rs1_id || s.rd_ex == s.rs2_id);
        e.f1 = fwd_model(s.rs1_ex, s.rd_mem, s.wr_mem, s.rd_wb, s.wr_wb);
        e.f2 = fwd_model(s.rs2_ex, s.rd_mem, s.wr_mem, s.rd_wb, s.wr_wb);
        e.st = 0; e.bu = 0; e.fl = 0;
        e.scnt = sat(n_stall);
        e.fcnt = sat(n_flush);
        e.chk_run = chk_run;
        e.tag = tag;
        if (!s.rst_n) begin
            pen_kind = 0; pen_left = 0; n_stall = 0; n_flush = 0;
        end else if (pen_kind == 2 && pen_left > 0) begin
            e.fl = 1; e.bu = 1; pen_left--;
        end else if (s.br) begin
            e.fl = 1; e.bu = 1; pen_kind = 2; pen_left = FLUSH_CYC - 1;
        end else if (pen_kind == 1 && pen_left > 0) begin
            e.st = 1; e.bu = 1; pen_left--;
        end else if (lu) begin
            e.st = 1; e.bu = 1; pen_kind = 1; pen_left = LDU_CYC - 1;
        end
        if (s.rst_n) begin
            n_stall += e.st;
            n_flush += e.fl;
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input string nm, input int act, input int want);
        checks_total++;
        if (act == want) checks_passed++;
        else $display("FAIL %s %s: got %0d, want %0d", tag, nm, act, want);
    endtask

    // Monitor: outputs are settled mid-cycle, compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn_no++;
                $display("txn %0d %s: fwd=%0d/%0d stall=%0b bubble=%0b flush=%0b", txn_no, e.tag,
                         hz.src1_fwd, hz.src2_fwd, hz.stall_if_id, hz.bubble_ex, hz.flush_if_id);
                check(e.tag, "src1_fwd", int'(hz.src1_fwd), e.f1);
                check(e.tag, "src2_fwd", int'(hz.src2_fwd), e.f2);
                check(e.tag, "stall_if_id", int'(hz.stall_if_id), e.st);
                check(e.tag, "bubble_ex", int'(hz.bubble_ex), e.bu);
                check(e.tag, "flush_if_id", int'(hz.flush_if_id), e.fl);
`ifdef HAZARD_PERF_CNT_EN
                check(e.tag, "stall_cnt", int'(stall_cnt), e.scnt);
                check(e.tag, "flush_cnt", int'(flush_cnt), e.fcnt);
`endif
                if (e.chk_run) check(e.tag, "state", int'(dut.state_reg), int'(ST_RUN));
            end
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        apply(s);
        repeat (3) step(s, "reset", 1'b0);

        // Forwarding priority and the x0 exclusion
        s = idle();
        s.rs1_ex = 5; s.rd_mem = 5; s.wr_mem = 1; s.rd_wb = 5; s.wr_wb = 1;
        step(s, "fwd_mem", 1'b0);
        s.wr_mem = 0;
        step(s, "fwd_wb", 1'b0);
        s = idle();
        s.rs2_ex = 0; s.rd_mem = 0; s.wr_mem = 1;
        step(s, "fwd_x0", 1'b0);

        // Load-use: hazard visible for one cycle, stall must last LDU_CYC cycles
        s = idle();
        s.load_ex = 1; s.rd_ex = 7; s.rs2_id = 7;
        step(s, "ldu", 1'b0);
        repeat (3) step(idle(), "ldu_tail", 1'b0);

        // Branch flush with a second branch inside the flush window
        s = idle(); s.br = 1;
        step(s, "br", 1'b0);
        step(s, "br_ignored", 1'b0);
        repeat (3) step(idle(), "br_tail", 1'b0);

        // Reset in the first LDSTALL cycle
        s = idle();
        s.load_ex = 1; s.rd_ex = 7; s.rs1_id = 7;
        step(s, "ldu_pre_rst", 1'b0);
        s.rst_n = 0;
        step(s, "rst_in_stall", 1'b0);
        step(idle(), "post_rst", 1'b1);
        step(idle(), "post_rst2", 1'b1);

        // Branch aborting a load-use stall
        s = idle();
        s.load_ex = 1; s.rd_ex = 3; s.rs1_id = 3;
        step(s, "ldu_abort", 1'b0);
        s.br = 1;
        step(s, "br_in_stall", 1'b0);
        repeat (3) step(idle(), "abort_tail", 1'b0);

        // Continuous load-use for 20 stall cycles saturates a 4-bit counter
        s = idle(); s.rst_n = 0;
        step(s, "rst_sat", 1'b0);
        s = idle();
        s.load_ex = 1; s.rd_ex = 9; s.rs2_id = 9;
        repeat (20) step(s, "sat", 1'b0);
        step(idle(), "sat_done", 1'b0);

        // Random traffic over a small register window to provoke frequent hits
        for (int i = 0; i < 300; i++) begin
            s.rst_n   = ($urandom_range(0, 49) != 0);
            s.rs1_id  = 5'($urandom_range(0, 7));
            s.rs2_id  = 5'($urandom_range(0, 7));
            s.rs1_ex  = 5'($urandom_range(0, 7));
            s.rs2_ex  = 5'($urandom_range(0, 7));
            s.rd_ex   = 5'($urandom_range(0, 7));
            s.rd_mem  = 5'($urandom_range(0, 7));
            s.rd_wb   = 5'($urandom_range(0, 7));
            s.load_ex = ($urandom_range(0, 2) == 0);
            s.wr_mem  = ($urandom_range(0, 1) == 0);
            s.wr_wb   = ($urandom_range(0, 1) == 0);
            s.br      = ($urandom_range(0, 7) == 0);
            step(s, "rand", 1'b0);
        end

        repeat (3) @(posedge clk);
        checks_total++;
        if (exp_q.size() == 0) checks_passed++;
        else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
